// File: rtl/lut_mult_sched.sv
// Two-requester round-robin scheduler for a shared pipelined LUT multiplier.
// Tracks each issued operation's owner through a tag pipeline and holds results until acknowledged.
module lut_mult_sched #(
  parameter int W   = 8,
  parameter int LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  output logic           grant0,
  output logic           rvalid0,
  output logic [2*W-1:0] rdata0,
  input  logic           rack0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           grant1,
  output logic           rvalid1,
  output logic [2*W-1:0] rdata1,
  input  logic           rack1,
  output logic           dp_en,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  input  logic [2*W-1:0] dp_result,
  output logic           busy
);

  logic [1:0]          req, rack, elig;
  logic [1:0][W-1:0]   op_a, op_b;
  logic [1:0]          grant_q, rvalid_q, inflight_q;
  logic [1:0][2*W-1:0] rdata_q;
  logic                ptr_q, win_vld, win_id;
  logic                dp_en_q, busy_q;
  logic [W-1:0]        dp_a_q, dp_b_q;
  logic [LAT:0]        tvld_q, tid_q, tvld_d, tid_d;

  assign req  = {req1, req0};
  assign rack = {rack1, rack0};
  assign op_a = {a1, a0};
  assign op_b = {b1, b0};

  // Slot k holds the tag issued k cycles ago; slot LAT lines up with dp_result.
  always_comb begin
    elig    = req & ~inflight_q & ~rvalid_q;
    win_vld = |elig;
    win_id  = (&elig) ? ptr_q : elig[1];
    tvld_d  = {tvld_q[LAT-1:0], win_vld};
    tid_d   = {tid_q[LAT-1:0], win_id};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q    <= '0;
      rvalid_q   <= '0;
      inflight_q <= '0;
      rdata_q    <= '0;
      ptr_q      <= 1'b0;
      dp_en_q    <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      busy_q     <= 1'b0;
      tvld_q     <= '0;
      tid_q      <= '0;
    end else begin
      grant_q <= '0;
      dp_en_q <= win_vld;
      if (win_vld) begin
        grant_q[win_id] <= 1'b1;
        ptr_q           <= ~win_id;
        dp_a_q          <= op_a[win_id];
        dp_b_q          <= op_b[win_id];
      end
      tvld_q <= tvld_d;
      tid_q  <= tid_d;
      busy_q <= |tvld_d;
      // A capture and an ack never target the same requester on one edge.
      for (int i = 0; i < 2; i++) begin
        if (tvld_q[LAT] && tid_q[LAT] == 1'(i)) begin
          rdata_q[i]    <= dp_result;
          rvalid_q[i]   <= 1'b1;
          inflight_q[i] <= 1'b0;
        end else if (rvalid_q[i] && rack[i]) begin
          rvalid_q[i] <= 1'b0;
        end
        if (win_vld && win_id == 1'(i)) inflight_q[i] <= 1'b1;
      end
    end
  end

  assign grant0  = grant_q[0];
  assign grant1  = grant_q[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign rdata0  = rdata_q[0];
  assign rdata1  = rdata_q[1];
  assign dp_en   = dp_en_q;
  assign dp_a    = dp_a_q;
  assign dp_b    = dp_b_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_lut_mult_sched.sv
// Directed bench for lut_mult_sched with a LAT-stage a*b datapath model.
module tb_lut_mult_sched;
  localparam int W   = 8;
  localparam int LAT = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, req1 = 0, rack0 = 0, rack1 = 0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic grant0, grant1, rvalid0, rvalid1, dp_en, busy;
  logic [2*W-1:0] rdata0, rdata1, dp_result;
  logic [W-1:0] dp_a, dp_b;

  lut_mult_sched #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .grant0(grant0), .rvalid0(rvalid0), .rdata0(rdata0), .rack0(rack0),
    .req1(req1), .a1(a1), .b1(b1), .grant1(grant1), .rvalid1(rvalid1), .rdata1(rdata1), .rack1(rack1),
    .dp_en(dp_en), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath model: product of the operands in cycle n appears in cycle n+LAT.
  logic signed [2*W-1:0] prod;
  logic [2*W-1:0] pipe [LAT];
  assign prod = $signed(dp_a) * $signed(dp_b);
  always @(posedge clk) begin
    pipe[0] <= prod;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign dp_result = pipe[LAT-1];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drain();
    req0 = 0; req1 = 0;
    repeat (12) begin
      @(negedge clk);
      rack0 = rvalid0; rack1 = rvalid1;
    end
    rack0 = 0; rack1 = 0;
  endtask

  task automatic wait_rv(input bit id, input string nm);
    int c = 0;
    while ((id ? rvalid1 : rvalid0) !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 32'(c < 10), 32'd1);
  endtask

  typedef struct {
    logic [W-1:0]   a0, b0, a1, b1;
    logic [2*W-1:0] e0, e1;
  } vec_t;
  vec_t tv[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{8'd7,   8'd6,   8'hFE, 8'd9,   16'h002A, 16'hFFEE};
    tv[1] = '{8'h7F,  8'h80,  8'h80, 8'h80,  16'hC080, 16'h4000};
    tv[2] = '{8'd0,   8'hFF,  8'hFF, 8'hFF,  16'h0000, 16'h0001};
    tv[3] = '{8'd1,   8'h7F,  8'h80, 8'd1,   16'h007F, 16'hFF80};

    // Reset state
    @(negedge clk);
    chk("rst_flags", {grant0, grant1, rvalid0, rvalid1, dp_en, busy}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_dp_ab", {dp_a, dp_b}, 0);
    rst = 0;

    // Simultaneous requests: grant0 at n, grant1 at n+1, captures at n+4 / n+5
    for (int i = 0; i < 4; i++) begin
      req0 = 1; req1 = 1;
      a0 = tv[i].a0; b0 = tv[i].b0; a1 = tv[i].a1; b1 = tv[i].b1;
      @(negedge clk);
      chk("tbl_grant_n", {grant0, grant1, dp_en, busy}, 4'b1011);
      chk("tbl_dp_a0", dp_a, tv[i].a0);
      req0 = 0;
      @(negedge clk);
      chk("tbl_grant_n1", {grant0, grant1, dp_en}, 3'b011);
      chk("tbl_dp_b1", dp_b, tv[i].b1);
      req1 = 0;
      repeat (3) @(negedge clk);
      chk("tbl_rv_n4", {rvalid0, rvalid1, busy}, 3'b101);
      chk("tbl_rdata0", rdata0, tv[i].e0);
      @(negedge clk);
      chk("tbl_rv_n5", {rvalid0, rvalid1, busy}, 3'b110);
      chk("tbl_rdata1", rdata1, tv[i].e1);
      rack0 = 1; rack1 = 1;
      @(negedge clk);
      rack0 = 0; rack1 = 0;
      chk("tbl_ack", {rvalid0, rvalid1}, 0);
    end

    // Basic single op: 5 * -3
    req0 = 1; a0 = 8'd5; b0 = 8'hFD;
    @(negedge clk);
    chk("basic_grant", {grant0, grant1, dp_en}, 3'b101);
    chk("basic_dp", {dp_a, dp_b}, 16'h05FD);
    req0 = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("basic_rv_early", rvalid0, 0);
      if (k == 1) chk("basic_pulse", {grant0, dp_en, dp_a}, {2'b00, 8'h05});
    end
    @(negedge clk);
    chk("basic_rv", rvalid0, 1);
    chk("basic_rdata", rdata0, 16'hFFF1);
    repeat (3) @(negedge clk);
    chk("basic_hold", {rvalid0, rdata0}, {1'b1, 16'hFFF1});
    rack0 = 1;
    @(negedge clk);
    rack0 = 0;
    chk("basic_ack", {rvalid0, rdata0}, {1'b0, 16'hFFF1});

    // Round robin: pointer sits at requester 1 after the lone grant0
    begin
      int got = 0;
      logic exp_id = 1'b1;
      req0 = 1; req1 = 1; a0 = 8'd2; b0 = 8'd2; a1 = 8'd3; b1 = 8'd3;
      for (int c = 0; c < 200 && got < 12; c++) begin
        @(negedge clk);
        if (grant0 || grant1) begin
          chk("rr_onehot", {grant0, grant1} == 2'b11, 0);
          chk("rr_order", grant1, exp_id);
          exp_id = ~exp_id;
          got++;
          if (got == 12) begin req0 = 0; req1 = 0; end
        end
        rack0 = rvalid0; rack1 = rvalid1;
      end
      chk("rr_count", got, 12);
      drain();
    end

    // Result hold with rack withheld
    req0 = 1; a0 = 8'h80; b0 = 8'h80;
    @(negedge clk);
    chk("hold_grant", grant0, 1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk("hold_state", {rvalid0, grant0, rdata0}, {2'b10, 16'h4000});
      @(negedge clk);
    end
    rack0 = 1;
    @(negedge clk);
    rack0 = 0;
    chk("hold_ack", {rvalid0, grant0, rdata0}, {2'b00, 16'h4000});
    @(negedge clk);
    chk("hold_regrant", grant0, 1);
    drain();

    // Extreme operands on requester 1; rack0 on requester 1's capture edge
    req0 = 1; a0 = 8'd2; b0 = 8'd3;
    @(negedge clk);
    chk("ext_grant0", grant0, 1);
    req0 = 0; req1 = 1; a1 = 8'h7F; b1 = 8'h80;
    @(negedge clk);
    chk("ext_grant1", grant1, 1);
    req1 = 0;
    repeat (3) @(negedge clk);
    chk("ext_rv0", {rvalid0, rvalid1, rdata0}, {2'b10, 16'h0006});
    rack0 = 1;
    @(negedge clk);
    rack0 = 0;
    chk("ext_both", {rvalid0, rvalid1}, 2'b01);
    chk("ext_rdata1", rdata1, 16'hC080);
    chk("ext_rdata0_keep", rdata0, 16'h0006);
    drain();

    // Reset two cycles after grant0
    req0 = 1; a0 = 8'd4; b0 = 8'd5;
    @(negedge clk);
    chk("mid_grant", grant0, 1);
    req0 = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("mid_async", {grant0, grant1, rvalid0, rvalid1, dp_en, busy, dp_a, dp_b}, 0);
    @(negedge clk);
    rst = 0;
    begin
      logic seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        seen = seen | rvalid0;
      end
      chk("mid_no_rv", seen, 0);
    end
    req0 = 1; a0 = 8'd3; b0 = 8'd3; req1 = 1; a1 = 8'hFD; b1 = 8'd3;
    @(negedge clk);
    chk("mid_first_grant", {grant0, grant1}, 2'b10);
    req0 = 0;
    @(negedge clk);
    chk("mid_second_grant", {grant0, grant1}, 2'b01);
    req1 = 0;
    wait_rv(1'b0, "mid_rv0_timeout");
    chk("mid_rdata0", rdata0, 16'h0009);
    wait_rv(1'b1, "mid_rv1_timeout");
    chk("mid_rdata1", rdata1, 16'hFFF7);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
